// File: rtl/lane_scheduler.sv
// Intersection scheduler: picks one lane at a time from requests, densities, starvation
// and emergency inputs, grants it, tracks it back to red, then holds an all-red clearance.
module lane_scheduler #(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned ALL_RED_CYCLES = 3,
  parameter int unsigned MAX_SKIP       = 3,
  parameter int unsigned LEAVE_TIMEOUT  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LANES-1:0]         request,
  input  logic [2*NUM_LANES-1:0]       density,
  input  logic [NUM_LANES-1:0]         lane_red,
  input  logic                         emergency_valid,
  input  logic [$clog2(NUM_LANES)-1:0] emergency_lane,
  output logic [NUM_LANES-1:0]         grant,
  output logic [$clog2(NUM_LANES)-1:0] active_lane,
  output logic                         busy,
  output logic                         all_red,
  output logic                         fault
);

  localparam int unsigned LW = $clog2(NUM_LANES);

  typedef enum logic [2:0] {StSelect, StGrant, StWaitLeave, StWaitDone, StClear} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] active_q, active_d;
  logic [LW-1:0] last_q, last_d;
  logic [2:0]    skip_q [NUM_LANES];
  logic [2:0]    skip_d [NUM_LANES];
  logic [7:0]    tmo_q, tmo_d;
  logic [7:0]    clr_q, clr_d;
  logic          fault_q, fault_d;
  logic          all_red_q;

  logic [1:0]    dens [NUM_LANES];
  logic          emerg_ok;
  logic          any_req;
  logic [LW-1:0] winner;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_dens
    assign dens[g] = density[2*g +: 2];
  end

  // Out-of-range emergency lanes are treated as no emergency.
  assign emerg_ok = emergency_valid && (int'(emergency_lane) < NUM_LANES);
  assign any_req  = |request;

  // Winner search walks lanes in round-robin order starting just after last_q.
  always_comb begin
    logic [LW-1:0] idx;
    logic [LW-1:0] starve_idx;
    logic [LW-1:0] best_idx;
    logic [1:0]    best_dens;
    logic          found_starve;
    logic          found_dens;
    idx          = '0;
    starve_idx   = '0;
    best_idx     = '0;
    best_dens    = '0;
    found_starve = 1'b0;
    found_dens   = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = LW'((int'(last_q) + k) % NUM_LANES);
      if (request[idx]) begin
        if (!found_starve && (skip_q[idx] == 3'(MAX_SKIP))) begin
          found_starve = 1'b1;
          starve_idx   = idx;
        end
        if (!found_dens || (dens[idx] > best_dens)) begin
          found_dens = 1'b1;
          best_dens  = dens[idx];
          best_idx   = idx;
        end
      end
    end
    if (emerg_ok) begin
      winner = emergency_lane;
    end else if (found_starve) begin
      winner = starve_idx;
    end else begin
      winner = best_idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    last_d   = last_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    clr_d    = clr_q;
    fault_d  = fault_q;
    unique case (state_q)
      StSelect: begin
        if (any_req || emerg_ok) begin
          active_d = winner;
          state_d  = StGrant;
          for (int i = 0; i < NUM_LANES; i++) begin
            if (LW'(i) == winner) begin
              skip_d[i] = '0;
            end else if (request[i]) begin
              skip_d[i] = (skip_q[i] == 3'(MAX_SKIP)) ? skip_q[i] : skip_q[i] + 3'd1;
            end else begin
              skip_d[i] = '0;
            end
          end
        end
      end
      StGrant: begin
        last_d  = active_q;
        tmo_d   = '0;
        state_d = StWaitLeave;
      end
      StWaitLeave: begin
        if (!lane_red[active_q]) begin
          state_d = StWaitDone;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == 8'(LEAVE_TIMEOUT - 1)) begin
            fault_d = 1'b1;
            clr_d   = '0;
            state_d = StClear;
          end
        end
      end
      StWaitDone: begin
        if (lane_red[active_q]) begin
          clr_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (clr_q == 8'(ALL_RED_CYCLES - 1)) begin
          state_d = StSelect;
        end else begin
          clr_d = clr_q + 8'd1;
        end
      end
      default: state_d = StSelect;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StSelect;
      active_q  <= '0;
      last_q    <= LW'(NUM_LANES - 1);
      tmo_q     <= '0;
      clr_q     <= '0;
      fault_q   <= 1'b0;
      all_red_q <= 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
        skip_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      clr_q     <= clr_d;
      fault_q   <= fault_d;
      all_red_q <= (state_d == StSelect) || (state_d == StClear);
      for (int i = 0; i < NUM_LANES; i++) begin
        skip_q[i] <= skip_d[i];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == StGrant) begin
      grant[active_q] = 1'b1;
    end
  end

  assign busy        = (state_q != StSelect);
  assign all_red     = all_red_q;
  assign active_lane = active_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Scoreboard bench for lane_scheduler: expected grant lanes are queued by the stimulus and
// popped by a monitor whenever a grant appears; a behavioural lane model drives lane_red.
module tb_lane_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] request = '0;
  logic [7:0] density = '0;
  logic [3:0] lane_red = 4'b1111;
  logic       emergency_valid = 1'b0;
  logic [1:0] emergency_lane = '0;
  logic [3:0] grant;
  logic [1:0] active_lane;
  logic       busy;
  logic       all_red;
  logic       fault;

  logic [3:0] stuck = '0;
  int         exp_q[$];
  int         checks = 0;
  int         errors = 0;

  lane_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .request         (request),
    .density         (density),
    .lane_red        (lane_red),
    .emergency_valid (emergency_valid),
    .emergency_lane  (emergency_lane),
    .grant           (grant),
    .active_lane     (active_lane),
    .busy            (busy),
    .all_red         (all_red),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Lane model: red drops two cycles after the grant pulse, stays out of red three cycles.
  initial begin
    int t[4];
    for (int i = 0; i < 4; i++) t[i] = -1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (reset) begin
          t[i] = -1;
        end else if (grant[i]) begin
          t[i] = 0;
        end else if (t[i] >= 0) begin
          t[i]++;
        end
        if (t[i] > 5) t[i] = -1;
        lane_red[i] = !((t[i] >= 2) && (t[i] <= 4) && !stuck[i]);
      end
    end
  end

  // Monitor: every grant cycle must match the next queued lane.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!reset && (grant !== 4'b0000)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant actual=%b required=none", grant);
        end else begin
          e = exp_q.pop_front();
          check("grant_onehot", 32'(grant), 32'(1) << e);
          check("grant_active_lane", 32'(active_lane), 32'(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic wait_grant();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((grant == 4'b0000) && (n < 200));
    check("grant_timeout", 32'(grant != 4'b0000), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    reset           = 1'b1;
    request         = '0;
    density         = '0;
    emergency_valid = 1'b0;
    emergency_lane  = '0;
    stuck           = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int busy_cnt;
    int clr_cnt;
    int order[4];

    // Reset values, then single request on lane 2.
    request = 4'b0100;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_active", 32'(active_lane), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_all_red", 32'(all_red), 32'd1);
    check("rst_fault", 32'(fault), 32'd0);
    exp_q.push_back(2);
    reset    = 1'b0;
    busy_cnt = 0;
    clr_cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("lat_grant", 32'(grant), 32'b0100);
        check("lat_all_red", 32'(all_red), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
      end
      if (i == 1) begin
        check("grant_pulse", 32'(grant), 32'd0);
        request = 4'b0000;
      end
      if (busy) busy_cnt++;
      if (busy && all_red) clr_cnt++;
    end
    // grant 1 + wait_leave 2 + wait_done 3 + clear 3
    check("busy_cycles", 32'(busy_cnt), 32'd9);
    check("clear_cycles", 32'(clr_cnt), 32'd3);
    check("idle_active", 32'(active_lane), 32'd2);
    check("idle_all_red", 32'(all_red), 32'd1);
    drain();

    // Density {1,3,2,3}; each served lane drops its request.
    apply_reset();
    request  = 4'b1111;
    density  = 8'b11_10_11_01;
    reset    = 1'b0;
    order[0] = 1;
    order[1] = 3;
    order[2] = 2;
    order[3] = 0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(order[k]);
      wait_grant();
      request = request & ~(4'b0001 << order[k]);
    end
    drain();

    // Starvation: lane 1 forced in at the 4th selection.
    apply_reset();
    request = 4'b0011;
    density = 8'b00_00_00_11;
    reset   = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(0);
    for (int k = 0; k < 5; k++) wait_grant();
    request = 4'b0000;
    drain();

    // Emergency with no request, then an emergency raised while lane 0 is out of red.
    apply_reset();
    emergency_valid = 1'b1;
    emergency_lane  = 2'd2;
    reset           = 1'b0;
    exp_q.push_back(2);
    wait_grant();
    emergency_valid = 1'b0;
    request         = 4'b0001;
    exp_q.push_back(0);
    wait_grant();
    request = 4'b0000;
    repeat (2) @(negedge clk);
    emergency_valid = 1'b1;
    emergency_lane  = 2'd3;
    exp_q.push_back(3);
    @(negedge clk);
    check("no_preempt_active", 32'(active_lane), 32'd0);
    check("no_preempt_busy", 32'(busy), 32'd1);
    wait_grant();
    emergency_valid = 1'b0;
    drain();

    // Leave timeout on a lane stuck at red.
    apply_reset();
    stuck   = 4'b0010;
    request = 4'b0010;
    reset   = 1'b0;
    exp_q.push_back(1);
    wait_grant();
    request = 4'b0100;
    repeat (4) @(negedge clk);
    check("fault_before_timeout", 32'(fault), 32'd0);
    @(negedge clk);
    check("fault_at_timeout", 32'(fault), 32'd1);
    check("fault_clear_busy", 32'(busy), 32'd1);
    check("fault_clear_all_red", 32'(all_red), 32'd1);
    stuck = 4'b0000;
    exp_q.push_back(2);
    wait_grant();
    request = 4'b0000;
    check("fault_sticky", 32'(fault), 32'd1);
    drain();

    // Reset while lane 2 is out of red; last_served must return to lane 3.
    apply_reset();
    request = 4'b0100;
    reset   = 1'b0;
    exp_q.push_back(2);
    wait_grant();
    request = 4'b0000;
    repeat (3) @(negedge clk);
    check("wd_busy", 32'(busy), 32'd1);
    check("wd_all_red", 32'(all_red), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_all_red", 32'(all_red), 32'd1);
    check("mid_rst_active", 32'(active_lane), 32'd0);
    check("mid_rst_fault", 32'(fault), 32'd0);
    request = 4'b1111;
    density = 8'b00_00_00_00;
    exp_q.push_back(0);
    @(negedge clk);
    reset = 1'b0;
    wait_grant();
    request = 4'b0000;
    drain();

    repeat (30) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
